usb_fs_tx_fetch: RTL and testbench

//  Upstream feeder for the full-speed serialiser. On start, streams the payload of one packet

---
 rtl/usb_fs_tx_fetch.sv | 216 +++++++++++++++++++++
 tb/tb_usb_fs_tx_fetch.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_fs_tx_fetch.sv
// usb_fs_tx_fetch: streams one packet buffer from 32-bit packet SRAM to the
// full-speed serialiser a byte at a time, keeping a two-word prefetch queue
// so the next byte is ready well before the serialiser's next byte slot.
module usb_fs_tx_fetch #(
    parameter  int unsigned NBuf           = 32,
    parameter  int unsigned MaxPktSizeByte = 64,
    localparam int unsigned NBufWidth      = $clog2(NBuf),
    localparam int unsigned SizeWidth      = $clog2(MaxPktSizeByte + 1),
    localparam int unsigned AddrW          = NBufWidth + $clog2(MaxPktSizeByte / 4)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 link_reset_i,
    input  logic                 start_i,
    input  logic [NBufWidth-1:0] buf_i,
    input  logic [SizeWidth-1:0] size_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 mem_req_o,
    output logic [AddrW-1:0]     mem_addr_o,
    input  logic                 mem_gnt_i,
    input  logic                 mem_rvalid_i,
    input  logic [31:0]          mem_rdata_i,
    output logic                 tx_data_avail_o,
    input  logic                 tx_data_get_i,
    output logic [7:0]           tx_data_o
);

    localparam int unsigned WordIdxW = $clog2(MaxPktSizeByte / 4);
    localparam int unsigned WordCntW = SizeWidth - 1;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StActive = 2'd1,
        StDrain  = 2'd2
    } state_e;

    state_e               r_state;
    state_e               w_state_next;

    logic [NBufWidth-1:0] r_buf;
    logic [SizeWidth-1:0] r_bytes_left;
    logic [WordCntW-1:0]  r_words_left;
    logic [WordIdxW-1:0]  r_fetch_idx;
    logic [1:0]           r_byte_idx;
    logic [31:0]          r_cur;
    logic [31:0]          r_nxt;
    logic                 r_cur_valid;
    logic                 r_nxt_valid;
    logic                 r_req;
    logic [AddrW-1:0]     r_addr;
    logic                 r_outstanding;
    logic                 r_done;

    logic                 w_busy;
    logic                 w_avail;
    logic                 w_issue;
    logic [7:0]           w_byte;
    logic                 w_get;
    logic                 w_last;
    logic                 w_shift;
    logic                 w_rd_ok;
    logic                 w_inflight_keep;
    logic [SizeWidth-1:0] w_size_clamped;
    logic [WordCntW-1:0]  w_words;
    logic [31:0]          w_cur_sh;
    logic                 w_cur_valid_sh;
    logic                 w_nxt_valid_sh;

    // Handshake qualifiers, size clamp and word count for a new packet
    always_comb begin
        w_get           = tx_data_get_i & w_avail;
        w_last          = w_get & (r_bytes_left == SizeWidth'(1));
        w_shift         = w_get & ((r_byte_idx == 2'd3) | w_last);
        w_rd_ok         = mem_rvalid_i & r_outstanding;
        w_inflight_keep = (r_outstanding & ~mem_rvalid_i) | (r_req & mem_gnt_i);
        w_size_clamped  = (size_i > SizeWidth'(MaxPktSizeByte)) ?
                          SizeWidth'(MaxPktSizeByte) : size_i;
        w_words         = WordCntW'((w_size_clamped + SizeWidth'(3)) >> 2);
    end

    // Queue contents after this cycle's consume shift, before any refill
    always_comb begin
        w_cur_sh       = r_cur;
        w_cur_valid_sh = r_cur_valid;
        w_nxt_valid_sh = r_nxt_valid;
        if (w_shift) begin
            w_cur_sh       = r_nxt;
            w_cur_valid_sh = r_nxt_valid;
            w_nxt_valid_sh = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a bus reset parks in Drain only while a read is in flight
    always_comb begin
        w_state_next = r_state;
        if (link_reset_i) begin
            w_state_next = w_inflight_keep ? StDrain : StIdle;
        end else begin
            case (r_state)
                StIdle:   if (start_i && (w_size_clamped != '0)) w_state_next = StActive;
                StActive: if (w_last) w_state_next = StIdle;
                StDrain:  if (w_rd_ok) w_state_next = StIdle;
                default:  w_state_next = StIdle;
            endcase
        end
    end

    // State-derived outputs: busy, byte available, read issue and byte select
    always_comb begin
        w_busy  = (r_state != StIdle);
        w_avail = (r_state == StActive) & r_cur_valid & (r_bytes_left != '0);
        w_issue = (r_state == StActive) & (r_words_left != '0) &
                  ~(r_cur_valid & r_nxt_valid) & ~r_req & ~r_outstanding;
        case (r_byte_idx)
            2'd0:    w_byte = r_cur[7:0];
            2'd1:    w_byte = r_cur[15:8];
            2'd2:    w_byte = r_cur[23:16];
            default: w_byte = r_cur[31:24];
        endcase
    end

    // Datapath: SRAM read handshake, prefetch queue, byte counters, done pulse
    always_ff @(posedge clk_i) begin
        if (!rst_ni || link_reset_i) begin
            r_buf         <= '0;
            r_bytes_left  <= '0;
            r_words_left  <= '0;
            r_fetch_idx   <= '0;
            r_byte_idx    <= '0;
            r_cur         <= '0;
            r_nxt         <= '0;
            r_cur_valid   <= 1'b0;
            r_nxt_valid   <= 1'b0;
            r_req         <= 1'b0;
            r_addr        <= '0;
            r_done        <= 1'b0;
            r_outstanding <= rst_ni ? w_inflight_keep : 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_cur       <= w_cur_sh;
            r_cur_valid <= w_cur_valid_sh;
            r_nxt_valid <= w_nxt_valid_sh;

            if (r_req && mem_gnt_i) begin
                r_req         <= 1'b0;
                r_outstanding <= 1'b1;
            end else if (w_issue) begin
                r_req        <= 1'b1;
                r_addr       <= {r_buf, r_fetch_idx};
                r_fetch_idx  <= r_fetch_idx + WordIdxW'(1);
                r_words_left <= r_words_left - WordCntW'(1);
            end

            // Returning word lands in whichever slot is empty after the shift;
            // in Drain it is dropped.
            if (w_rd_ok) begin
                r_outstanding <= 1'b0;
                if (r_state == StActive) begin
                    if (!w_cur_valid_sh) begin
                        r_cur       <= mem_rdata_i;
                        r_cur_valid <= 1'b1;
                    end else begin
                        r_nxt       <= mem_rdata_i;
                        r_nxt_valid <= 1'b1;
                    end
                end
            end

            if (w_get) begin
                r_bytes_left <= r_bytes_left - SizeWidth'(1);
                r_byte_idx   <= r_byte_idx + 2'd1;
                if (w_last) r_done <= 1'b1;
            end

            if ((r_state == StIdle) && start_i) begin
                r_buf        <= buf_i;
                r_bytes_left <= w_size_clamped;
                r_words_left <= w_words;
                r_fetch_idx  <= '0;
                r_byte_idx   <= '0;
                r_cur_valid  <= 1'b0;
                r_nxt_valid  <= 1'b0;
                if (w_size_clamped == '0) r_done <= 1'b1;
            end
        end
    end

    assign busy_o          = w_busy;
    assign done_o          = r_done;
    assign mem_req_o       = r_req;
    assign mem_addr_o      = r_addr;
    assign tx_data_avail_o = w_avail;
    assign tx_data_o       = w_byte;

    // Protocol checks
    a_state_range: assert property (@(posedge clk_i)
        r_state inside {StIdle, StActive, StDrain});
    a_addr_stable: assert property (@(posedge clk_i)
        (rst_ni && !link_reset_i && mem_req_o && !mem_gnt_i) |=> $stable(mem_addr_o));
    a_avail_busy: assert property (@(posedge clk_i)
        tx_data_avail_o |-> busy_o);
    a_start_idle: assert property (@(posedge clk_i)
        !(rst_ni && !link_reset_i && start_i && busy_o))
        else $warning("usb_fs_tx_fetch: start_i while busy_o, protocol error");

endmodule

// File: tb/tb_usb_fs_tx_fetch.sv
// tb_usb_fs_tx_fetch: directed scenarios with an SRAM responder and a byte/address scoreboard.
module tb_usb_fs_tx_fetch;

    logic        clk;
    logic        rst_n;
    logic        link_reset;
    logic        start;
    logic [4:0]  buf_sel;
    logic [6:0]  size;
    logic        busy;
    logic        done;
    logic        req;
    logic [8:0]  addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        avail;
    logic        get;
    logic [7:0]  tx_data;

    logic [31:0] mem [512];
    logic [7:0]  exp_q[$];
    logic [8:0]  exp_addr_q[$];
    logic [8:0]  act_addr_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    int         gnt_dly = 0;
    int         rv_dly  = 1;
    int         gnt_cnt = 0;
    int         rv_cnt  = 0;
    bit         rv_pending = 0;
    logic [8:0] rv_addr = '0;

    usb_fs_tx_fetch dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .link_reset_i    (link_reset),
        .start_i         (start),
        .buf_i           (buf_sel),
        .size_i          (size),
        .busy_o          (busy),
        .done_o          (done),
        .mem_req_o       (req),
        .mem_addr_o      (addr),
        .mem_gnt_i       (gnt),
        .mem_rvalid_i    (rvalid),
        .mem_rdata_i     (rdata),
        .tx_data_avail_o (avail),
        .tx_data_get_i   (get),
        .tx_data_o       (tx_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SRAM responder: grant after gnt_dly cycles of request, data rv_dly cycles after grant
    initial begin
        gnt    = 1'b0;
        rvalid = 1'b0;
        rdata  = '0;
        forever begin
            @(negedge clk);
            gnt    = 1'b0;
            rvalid = 1'b0;
            if (rv_pending) begin
                rv_cnt--;
                if (rv_cnt <= 0) begin
                    rvalid     = 1'b1;
                    rdata      = mem[rv_addr];
                    rv_pending = 0;
                end
            end
            if (req) begin
                if (gnt_cnt >= gnt_dly) begin
                    gnt        = 1'b1;
                    gnt_cnt    = 0;
                    act_addr_q.push_back(addr);
                    rv_addr    = addr;
                    rv_cnt     = rv_dly;
                    rv_pending = 1;
                end else begin
                    gnt_cnt++;
                end
            end else begin
                gnt_cnt = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Push expected bytes and read addresses, then pulse start_i
    task automatic start_pkt(input logic [4:0] b, input logic [6:0] sz);
        int eff;
        logic [31:0] wd;
        eff = (sz > 7'd64) ? 64 : int'(sz);
        for (int i = 0; i < eff; i++) begin
            wd = mem[{b, 4'(i / 4)}];
            exp_q.push_back(wd[8*(i%4) +: 8]);
        end
        for (int w = 0; w < (eff + 3) / 4; w++) exp_addr_q.push_back({b, 4'(w)});
        buf_sel = b;
        size    = sz;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    // Take n bytes, one get at least every period cycles, scoring each byte
    task automatic consume(input string tn, input int n, input int period,
                           input bit gapchk, output bit ok);
        int gaps;
        int t;
        logic [7:0] e;
        gaps = 0;
        ok   = 1'b1;
        for (int i = 0; i < n; i++) begin
            t = 0;
            while (!avail && t < 500) begin
                @(negedge clk);
                t++;
            end
            if (!avail) begin
                chk({tn, " avail timeout"}, 32'(avail), 32'd1);
                ok = 1'b0;
                return;
            end
            if (exp_q.size() != 0) e = exp_q.pop_front();
            else e = 8'hxx;
            chk($sformatf("%s byte %0d", tn, i), 32'(tx_data), 32'(e));
            get = 1'b1;
            @(negedge clk);
            get = 1'b0;
            if (i < n - 1) begin
                for (int p = 1; p < period; p++) begin
                    if (gapchk && !avail) gaps++;
                    @(negedge clk);
                end
            end
        end
        if (gapchk) chk({tn, " avail gaps"}, 32'(gaps), 32'd0);
    endtask

    task automatic check_reads(input string tn);
        chk({tn, " read count"}, 32'(act_addr_q.size()), 32'(exp_addr_q.size()));
        for (int k = 0; k < exp_addr_q.size() && k < act_addr_q.size(); k++)
            chk($sformatf("%s read addr %0d", tn, k), 32'(act_addr_q[k]), 32'(exp_addr_q[k]));
        exp_addr_q.delete();
        act_addr_q.delete();
    endtask

    task automatic run_packet(input string tn, input logic [4:0] b, input logic [6:0] sz,
                              input int gd, input int rd, input int period, input bit gapchk);
        int eff;
        bit ok;
        eff     = (sz > 7'd64) ? 64 : int'(sz);
        gnt_dly = gd;
        rv_dly  = rd;
        act_addr_q.delete();
        start_pkt(b, sz);
        consume(tn, eff, period, gapchk, ok);
        if (ok) begin
            chk({tn, " done pulse"}, 32'(done), 32'd1);
            chk({tn, " busy at done"}, 32'(busy), 32'd0);
            chk({tn, " avail at done"}, 32'(avail), 32'd0);
            @(negedge clk);
            chk({tn, " done one cycle"}, 32'(done), 32'd0);
        end
        chk({tn, " bytes left in model"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        check_reads(tn);
    endtask

    initial begin
        int hits;
        int t;
        int nreads;
        bit ok;

        rst_n      = 1'b0;
        link_reset = 1'b0;
        start      = 1'b0;
        get        = 1'b0;
        buf_sel    = '0;
        size       = '0;
        for (int i = 0; i < 512; i++) mem[i] = $urandom;
        mem[9'h030] = 32'h4433_2211;
        mem[9'h031] = 32'h0000_00AA;

        repeat (3) @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset req", 32'(req), 32'd0);
        chk("reset addr", 32'(addr), 32'd0);
        chk("reset avail", 32'(avail), 32'd0);
        chk("reset data", 32'(tx_data), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // T1: two words, five bytes
        run_packet("T1", 5'd3, 7'd5, 0, 1, 1, 1'b0);

        // T2: empty packet
        act_addr_q.delete();
        start_pkt(5'd4, 7'd0);
        chk("T2 done after start", 32'(done), 32'd1);
        chk("T2 busy", 32'(busy), 32'd0);
        hits = 0;
        repeat (6) begin
            @(negedge clk);
            if (req || avail || done || busy) hits++;
        end
        chk("T2 quiet after done", 32'(hits), 32'd0);
        check_reads("T2");

        // T3: full buffer, slow serialiser, slow SRAM
        run_packet("T3", 5'd11, 7'd64, 3, 2, 32, 1'b1);

        // T4: oversize request is clamped; gets after done are ignored
        run_packet("T4", 5'd20, 7'd100, 1, 2, 2, 1'b0);
        nreads = act_addr_q.size();
        hits = 0;
        get = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (avail || done || req || busy) hits++;
        end
        get = 1'b0;
        chk("T4 extra gets ignored", 32'(hits), 32'd0);
        chk("T4 no extra reads", 32'(act_addr_q.size()), 32'(nreads));

        // T5: bus reset with a read outstanding, then a clean restart
        gnt_dly = 0;
        rv_dly  = 10;
        act_addr_q.delete();
        start_pkt(5'd7, 7'd20);
        consume("T5", 6, 1, 1'b0, ok);
        chk("T5 read outstanding", 32'(rv_pending), 32'd1);
        nreads = act_addr_q.size();
        link_reset = 1'b1;
        @(negedge clk);
        link_reset = 1'b0;
        chk("T5 avail drop", 32'(avail), 32'd0);
        chk("T5 req drop", 32'(req), 32'd0);
        chk("T5 done low", 32'(done), 32'd0);
        chk("T5 busy in drain", 32'(busy), 32'd1);
        buf_sel = 5'd2;
        size    = 7'd8;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        chk("T5 start in drain busy", 32'(busy), 32'd1);
        chk("T5 start in drain req", 32'(req), 32'd0);
        t = 0;
        while (busy && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("T5 drain ends", 32'(busy), 32'd0);
        chk("T5 avail after drain", 32'(avail), 32'd0);
        chk("T5 no reads after reset", 32'(act_addr_q.size()), 32'(nreads));
        exp_q.delete();
        exp_addr_q.delete();
        run_packet("T5 restart", 5'd7, 7'd20, 0, 3, 1, 1'b0);

        // T6: core reset mid-packet with a read in flight
        gnt_dly = 0;
        rv_dly  = 8;
        act_addr_q.delete();
        start_pkt(5'd9, 7'd12);
        consume("T6", 2, 1, 1'b0, ok);
        chk("T6 read outstanding", 32'(rv_pending), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("T6 busy", 32'(busy), 32'd0);
        chk("T6 done", 32'(done), 32'd0);
        chk("T6 req", 32'(req), 32'd0);
        chk("T6 addr", 32'(addr), 32'd0);
        chk("T6 avail", 32'(avail), 32'd0);
        chk("T6 data", 32'(tx_data), 32'd0);
        hits = 0;
        repeat (12) begin
            @(negedge clk);
            if (busy || avail || req || done) hits++;
        end
        chk("T6 stale rvalid ignored", 32'(hits), 32'd0);
        exp_q.delete();
        exp_addr_q.delete();
        run_packet("T6 restart", 5'd9, 7'd12, 2, 1, 1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
